// File: rtl/dac_pattern_pkg.sv
// Shared encodings for the DAC test-pattern generator: run modes, FSM states, MISR taps.
package dac_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_MID    = 3'd0,
    MODE_CONST  = 3'd1,
    MODE_RAMP   = 3'd2,
    MODE_TOGGLE = 3'd3,
    MODE_PAT    = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_FLUSH
  } state_e;

  // Feedback taps sig[31], sig[21], sig[1], sig[0].
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

  // Unused encodings 5-7 collapse onto midscale.
  function automatic mode_e decode_mode(input logic [2:0] m);
    if (m > 3'd4) return MODE_MID;
    return mode_e'(m);
  endfunction

endpackage

// File: rtl/dac_pattern_gen_if.sv
// Sample stream toward the DAC interface block; master drives data/valid, slave drives ready.
interface dac_pattern_gen_if #(
  parameter int W = 128
) ();
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/dac_pattern_ram.sv
// Simple dual-port pattern RAM, 1-cycle registered read; read-during-write returns old data.
module dac_pattern_ram #(
  parameter int W     = 128,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dac_pattern_gen.sv
// Multi-mode DAC test-pattern source; first word 2 cycles after start, output held under !out_ready.
// DAC_PATTERN_GEN_SIG_EN adds sig_out, a MISR signature over transferred words.
module dac_pattern_gen
  import dac_pattern_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LANES     = 4,
  parameter int NCH       = 2,
  parameter int PAT_DEPTH = 256,
  localparam int AW       = $clog2(PAT_DEPTH),
  localparam int W        = NCH * LANES * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  input  logic [DATA_W-1:0] ramp_step,
  input  logic [AW-1:0]     pat_last,
  input  logic [31:0]       burst_len,
  input  logic              pat_we,
  input  logic [AW-1:0]     pat_waddr,
  input  logic [W-1:0]      pat_wdata,
  dac_pattern_gen_if.master dac_if,
  output logic              running,
  output logic              done,
  output logic [31:0]       stall_cnt
`ifdef DAC_PATTERN_GEN_SIG_EN
  ,
  output logic [31:0]       sig_out
`endif
);

  state_e            state_q;
  mode_e             mode_q;
  logic [DATA_W-1:0] const_q, step_q, acc_q;
  logic [AW-1:0]     last_q, raddr_q, raddr_d, ram_raddr;
  logic [31:0]       burst_q, xfer_q, stall_q;
  logic [W-1:0]      data_q, word_d, ram_rdata;
  logic              valid_q, running_q, done_q;
  logic              xfer, start_ok, last_xfer, load, ram_re;
  logic [DATA_W-1:0] sample;

  assign xfer      = valid_q && dac_if.out_ready;
  assign start_ok  = (state_q == ST_IDLE) && start && !stop;
  assign last_xfer = xfer && (burst_q != 32'd0) && (xfer_q + 32'd1 == burst_q);
  // A new word is produced on ARM exit and on every non-final transfer in RUN.
  assign load      = ((state_q == ST_ARM) && !stop) ||
                     ((state_q == ST_RUN) && xfer && !stop && !last_xfer);
  assign raddr_d   = (raddr_q == last_q) ? '0 : raddr_q + 1'b1;
  assign ram_re    = start_ok || load;
  assign ram_raddr = start_ok ? '0 : raddr_d;

  dac_pattern_ram #(.W(W), .DEPTH(PAT_DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (pat_we),
    .waddr_i (pat_waddr),
    .wdata_i (pat_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    word_d = '0;
    sample = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < LANES; k++) begin
        case (mode_q)
          MODE_CONST:  sample = const_q;
          MODE_RAMP:   sample = acc_q + DATA_W'(k) * step_q;
          MODE_TOGGLE: sample = k[0] ? ~const_q : const_q;
          MODE_PAT:    sample = ram_rdata[(c*LANES+k)*DATA_W +: DATA_W];
          default:     sample = '0;
        endcase
        word_d[(c*LANES+k)*DATA_W +: DATA_W] = sample;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MID;
      const_q   <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      last_q    <= '0;
      raddr_q   <= '0;
      burst_q   <= '0;
      xfer_q    <= '0;
      stall_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (valid_q && !dac_if.out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (xfer) xfer_q <= xfer_q + 32'd1;
      if (load) begin
        data_q  <= word_d;
        valid_q <= 1'b1;
        acc_q   <= acc_q + DATA_W'(LANES) * step_q;
        raddr_q <= raddr_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            mode_q    <= decode_mode(mode);
            const_q   <= const_val;
            step_q    <= ramp_step;
            last_q    <= pat_last;
            burst_q   <= burst_len;
            stall_q   <= '0;
            xfer_q    <= '0;
            acc_q     <= '0;
            raddr_q   <= '0;
            running_q <= 1'b1;
            state_q   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (stop) begin
            running_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_xfer || (stop && xfer)) begin
            valid_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (stop) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (xfer) begin
            valid_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dac_if.out_data  = data_q;
  assign dac_if.out_valid = valid_q;
  assign running          = running_q;
  assign done             = done_q;
  assign stall_cnt        = stall_q;

`ifdef DAC_PATTERN_GEN_SIG_EN
  logic [31:0] fold32, sig_q;

  // Last slice is implicitly zero-padded when W is not a multiple of 32.
  always_comb begin
    fold32 = '0;
    for (int i = 0; i < W; i++) fold32[i[4:0]] = fold32[i[4:0]] ^ data_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sig_q <= '0;
    else if (start_ok) sig_q <= '0;
    else if (xfer)     sig_q <= {sig_q[30:0], ^(sig_q & MISR_TAPS)} ^ fold32;
  end

  assign sig_out = sig_q;
`endif

endmodule

// File: tb/tb_dac_pattern_gen.sv
// Bench for dac_pattern_gen: vector table of bursts with a word scoreboard, plus stop/reset sequences.
module tb_dac_pattern_gen;

  localparam int WW = 128;

  typedef struct {
    logic [2:0]   mode;
    logic [15:0]  cv;
    logic [15:0]  step;
    logic [7:0]   plast;
    logic [31:0]  blen;
    logic [7:0]   rdy;
    logic [127:0] w0;
    logic [127:0] wl;
    logic [31:0]  stall;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, pat_we = 1'b0;
  logic [2:0]    mode = '0;
  logic [15:0]   const_val = '0, ramp_step = '0;
  logic [7:0]    pat_last = '0, pat_waddr = '0;
  logic [31:0]   burst_len = '0;
  logic [WW-1:0] pat_wdata = '0;
  logic          running, done;
  logic [31:0]   stall_cnt;
`ifdef DAC_PATTERN_GEN_SIG_EN
  logic [31:0]   sig_out;
  logic [31:0]   sig_m;
`endif

  always #5 clk = ~clk;

  dac_pattern_gen_if #(.W(WW)) u_if ();

  dac_pattern_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .const_val (const_val),
    .ramp_step (ramp_step),
    .pat_last  (pat_last),
    .burst_len (burst_len),
    .pat_we    (pat_we),
    .pat_waddr (pat_waddr),
    .pat_wdata (pat_wdata),
    .dac_if    (u_if),
    .running   (running),
    .done      (done),
    .stall_cnt (stall_cnt)
`ifdef DAC_PATTERN_GEN_SIG_EN
    ,
    .sig_out   (sig_out)
`endif
  );

  int           n_checks = 0, n_errors = 0;
  int           cyc, first_v, done_cnt, xfers;
  logic [127:0] first_w, last_w;
  logic [127:0] exp_q[$];
  logic [127:0] pat_m [256];
  vec_t         vt [9];

  function automatic logic [127:0] lanes(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0, l3, l2, l1, l0};
  endfunction

  function automatic logic [127:0] model_word(input logic [2:0] m, input logic [15:0] cv, st,
                                              input logic [7:0] pl, input int n);
    logic [127:0] w;
    logic [15:0]  s;
    w = '0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        case (m)
          3'd1:    s = cv;
          3'd2:    s = 16'((n * 4 + k) * st);
          3'd3:    s = (k % 2 == 1) ? ~cv : cv;
          3'd4:    s = pat_m[n % (int'(pl) + 1)][(c*4+k)*16 +: 16];
          default: s = '0;
        endcase
        w[(c*4+k)*16 +: 16] = s;
      end
    end
    return w;
  endfunction

`ifdef DAC_PATTERN_GEN_SIG_EN
  function automatic logic [31:0] misr(input logic [31:0] s, input logic [127:0] w);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [127:0] e;
    if (u_if.out_valid && first_v < 0) first_v = cyc;
    if (done) done_cnt++;
    if (u_if.out_valid && u_if.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL extra_word: got %h expected no transfer", u_if.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("word", u_if.out_data, e);
`ifdef DAC_PATTERN_GEN_SIG_EN
        sig_m = misr(sig_m, e);
`endif
      end
      if (xfers == 0) first_w = u_if.out_data;
      last_w = u_if.out_data;
      xfers++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr_ram(input logic [7:0] a, input logic [127:0] d);
    pat_we = 1'b1; pat_waddr = a; pat_wdata = d; pat_m[a] = d;
    tick();
    pat_we = 1'b0;
  endtask

  task automatic begin_run(input logic [2:0] m, input logic [15:0] cv, st,
                           input logic [7:0] pl, input logic [31:0] bl);
    mode = m; const_val = cv; ramp_step = st; pat_last = pl; burst_len = bl;
    start = 1'b1;
    cyc = 0; first_v = -1; done_cnt = 0; xfers = 0;
`ifdef DAC_PATTERN_GEN_SIG_EN
    sig_m = '0;
`endif
  endtask

  task automatic run_burst(input vec_t v, input string nm);
    begin_run(v.mode, v.cv, v.step, v.plast, v.blen);
    for (int n = 0; n < int'(v.blen); n++) exp_q.push_back(model_word(v.mode, v.cv, v.step, v.plast, n));
    u_if.out_ready = v.rdy[0];
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && done_cnt == 0; i++) begin
      u_if.out_ready = v.rdy[cyc % 8];
      tick();
    end
    tick();
    tick();
    chk({nm, "_first_valid_cycle"}, 128'(first_v), 128'd2);
    chk({nm, "_xfers"}, 128'(xfers), 128'(v.blen));
    chk({nm, "_done_pulses"}, 128'(done_cnt), 128'd1);
    chk({nm, "_idle_running_valid"}, {126'd0, running, u_if.out_valid}, 128'd0);
    chk({nm, "_stall_cnt"}, 128'(stall_cnt), 128'(v.stall));
    chk({nm, "_first_word"}, first_w, v.w0);
    chk({nm, "_last_word"}, last_w, v.wl);
    chk({nm, "_queue_left"}, 128'(exp_q.size()), 128'd0);
`ifdef DAC_PATTERN_GEN_SIG_EN
    chk({nm, "_sig"}, 128'(sig_out), 128'(sig_m));
`endif
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] pa, pb, pc, beef;
    u_if.out_ready = 1'b0;
    cyc = 0; first_v = -1; done_cnt = 0; xfers = 0;
`ifdef DAC_PATTERN_GEN_SIG_EN
    sig_m = '0;
`endif
    #1;
    chk("reset_data", u_if.out_data, 128'd0);
    chk("reset_flags", {125'd0, u_if.out_valid, running, done}, 128'd0);
    chk("reset_stall", 128'(stall_cnt), 128'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    pc = {$urandom, $urandom, $urandom, $urandom};
    wr_ram(8'd0, pa);
    wr_ram(8'd1, pb);
    wr_ram(8'd2, pc);

    vt[0] = '{3'd2, 16'd0, 16'd3, 8'd0, 32'd4, 8'hFF,
              lanes(16'd0, 16'd3, 16'd6, 16'd9), lanes(16'd36, 16'd39, 16'd42, 16'd45), 32'd0};
    vt[1] = '{3'd1, 16'h1234, 16'd7, 8'd0, 32'd2, 8'b1110_0111,
              lanes(16'h1234, 16'h1234, 16'h1234, 16'h1234),
              lanes(16'h1234, 16'h1234, 16'h1234, 16'h1234), 32'd2};
    vt[2] = '{3'd4, 16'd0, 16'd0, 8'd2, 32'd7, 8'hFF, pa, pa, 32'd0};
    vt[3] = '{3'd3, 16'h00FF, 16'd0, 8'd0, 32'd3, 8'hFF,
              lanes(16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00),
              lanes(16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00), 32'd0};
    vt[4] = '{3'd2, 16'd0, 16'h4000, 8'd0, 32'd2, 8'hFF,
              lanes(16'h0000, 16'h4000, 16'h8000, 16'hC000),
              lanes(16'h0000, 16'h4000, 16'h8000, 16'hC000), 32'd0};
    vt[5] = '{3'd7, 16'h5555, 16'd1, 8'd0, 32'd2, 8'hFF, 128'd0, 128'd0, 32'd0};
    vt[6] = '{3'd4, 16'd0, 16'd0, 8'd0, 32'd3, 8'hFF, pa, pa, 32'd0};
    vt[7] = '{3'd4, 16'd0, 16'd0, 8'd1, 32'd4, 8'b1011_1011, pa, pb, 32'd2};
    vt[8] = '{3'd2, 16'd0, 16'd1, 8'd0, 32'd2, 8'hFF,
              lanes(16'd0, 16'd1, 16'd2, 16'd3), lanes(16'd4, 16'd5, 16'd6, 16'd7), 32'd0};

    for (int v = 0; v < 8; v++) run_burst(vt[v], $sformatf("vec%0d", v));

    // Stop while stalled: FLUSH must hold the word, then release exactly one transfer.
    beef = lanes(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    u_if.out_ready = 1'b0;
    begin_run(3'd1, 16'hBEEF, 16'd0, 8'd0, 32'd0);
    exp_q.push_back(beef);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("stall_hold_data", u_if.out_data, beef);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("flush_flags", {125'd0, running, u_if.out_valid, done}, 128'b110);
    tick();
    tick();
    chk("flush_hold_data", u_if.out_data, beef);
    u_if.out_ready = 1'b1;
    tick();
    chk("flush_exit_flags", {125'd0, running, u_if.out_valid, done}, 128'b001);
    chk("flush_stall_cnt", 128'(stall_cnt), 128'd6);
    chk("flush_xfers", 128'(xfers), 128'd1);
    tick();
    chk("flush_done_once", {127'd0, done}, 128'd0);

    // Start and stop together in IDLE: nothing happens.
    begin_run(3'd2, 16'd0, 16'd1, 8'd0, 32'd4);
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("start_stop_idle", {125'd0, running, u_if.out_valid, done}, 128'd0);
    end

    // Asynchronous reset mid-run, then a fresh ramp must start again from 0.
    u_if.out_ready = 1'b1;
    begin_run(3'd2, 16'd0, 16'd1, 8'd0, 32'd0);
    for (int n = 0; n < 4; n++) exp_q.push_back(model_word(3'd2, 16'd0, 16'd1, 8'd0, n));
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_reset_running", {127'd0, running}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {125'd0, running, u_if.out_valid, done}, 128'd0);
    chk("async_reset_data", u_if.out_data, 128'd0);
    chk("async_reset_stall", 128'(stall_cnt), 128'd0);
    chk("pre_reset_words", 128'(exp_q.size()), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_burst(vt[8], "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_pattern_gen.md
Name: dac_pattern_gen

Overview:
- Parametrised multi-channel DAC test-pattern source for the MKID readout DAC path.
- Emits LANES interleaved samples per clock per channel (4x interleave by default) into the DAC interface block over a valid/ready stream.
- Replaces the fixed single-mode DAC tester with modes selected at run time:
  - midscale,
  - constant,
  - ramp,
  - lane toggle,
  - RAM-pattern playback with burst/continuous control.

Parameters:
- DATA_W, 16, DAC sample width in bits (two's complement).
- LANES, 4, samples per clock per channel.
- NCH, 2, channels (I, Q).
- PAT_DEPTH, 256, pattern RAM words (power of two); AW = $clog2(PAT_DEPTH).

Ports:
- clk  in  1  fabric/DAC-interface clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: latch config, begin generation.
- stop  in  1  single-cycle pulse: end generation.
- mode  in  3  0 midscale, 1 constant, 2 ramp, 3 toggle, 4 pattern; 5-7 treated as 0.
- const_val  in  DATA_W  constant/toggle value.
- ramp_step  in  DATA_W  ramp increment per sample.
- pat_last  in  AW  last RAM address played before wrap.
- burst_len  in  32  words to emit; 0 = continuous.
- pat_we  in  1  pattern RAM write enable.
- pat_waddr  in  AW  pattern RAM write address.
- pat_wdata  in  NCH*LANES*DATA_W  RAM word; channel c, lane k at bits [(c*LANES+k)*DATA_W +: DATA_W].
- out_data  out  NCH*LANES*DATA_W  samples, same packing.
- out_valid  out  1  out_data valid.
- out_ready  in  1  DAC interface accepts word.
- running  out  1  generator active.
- done  out  1  one-cycle pulse on burst completion or stop.
- stall_cnt  out  32  cycles with out_valid && !out_ready since last start.

Behaviour:
- Reset: out_data=0, out_valid=0, running=0, done=0, stall_cnt=0, state IDLE, ramp accumulator 0, RAM read address 0. RAM contents are not reset.
- FSM states IDLE, ARM, RUN, FLUSH.
  - IDLE: start && !stop latches mode, const_val, ramp_step, pat_last and burst_len, clears stall_cnt and counters, and moves to ARM. Start and stop in the same cycle: stop wins, so the FSM stays in IDLE with no done pulse.
  - ARM: one cycle priming the RAM read of address 0. Then RUN. running=1 from ARM onward.
  - RUN:
    - A word transfers when out_valid && out_ready.
    - The output register holds stable while out_valid && !out_ready.
    - out_valid is first asserted 2 cycles after start. With out_ready held high, it stays high every cycle thereafter.
    - 1-entry prefetch buffer; the RAM address advances only when the buffer is consumed.
  - Stop in RUN: no new words are generated. If the current word is unaccepted, go to FLUSH; otherwise go to IDLE.
  - Burst complete (transfer count == burst_len, burst_len != 0): go to IDLE and pulse done in the cycle after the final transfer.
  - FLUSH: hold the word until it is accepted, then IDLE and pulse done.
  - IDLE or ARM entry leaves out_valid=0 and running=0 in IDLE.
- start while not IDLE: ignored. Config inputs change freely; they are sampled only at start.
- Sample generation, for word n (0-based), lane k, channel c:
  - Mode 0: 0 (midscale).
  - Mode 1: const_val.
  - Mode 2: base + (n*LANES+k)*ramp_step, mod 2^DATA_W. Accumulator advances by LANES*ramp_step per transfer. Identical on all channels. base = 0 at start.
  - Mode 3: lane k even gives const_val, odd gives ~const_val. Every word is identical.
  - Mode 4: RAM[n mod (pat_last+1)] unpacked per channel/lane. Address pat_last wraps to 0. pat_last=0 repeats word 0.
- RAM: simple dual-port, 1-cycle read latency. A write to the address currently being read returns the old data.
- stall_cnt saturates at 2^32-1.
- Async reset mid-burst: immediate return to reset values. No done pulse.

Optional Feature:
- Macro: DAC_PATTERN_GEN_SIG_EN.
- Defined:
  - Adds output port sig_out (32 bits): a MISR signature over transferred words.
  - Update on each transfer: sig = {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} XOR fold32(out_data), where fold32 XORs 32-bit slices and zero-pads the last slice.
  - Cleared to 0 at start and at reset.
  - Used for loopback compare against the ADC capture.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dac_pattern_pkg:
  - mode encodings MODE_MID, MODE_CONST, MODE_RAMP, MODE_TOGGLE, MODE_PAT;
  - FSM state typedef;
  - MISR tap constant.
- Sub-module dac_pattern_ram: parametrised simple dual-port RAM with 1-cycle read. Width NCH*LANES*DATA_W, depth PAT_DEPTH.

Test Plan:
- Ramp, out_ready=1: mode=2, ramp_step=3, burst_len=4 → valid from start+2 for 4 cycles. Word0 lanes {0,3,6,9}, word3 lanes {36,39,42,45}. done pulses once; running drops.
- Backpressure: mode=1, const_val=16'h1234, out_ready toggled 1,0,0,1 → data stable through stalls, stall_cnt=2, no duplicate or lost words.
- Pattern wrap: RAM words 0..2 = A,B,C; pat_last=2; burst_len=7 → sequence A,B,C,A,B,C,A.
- Toggle plus ramp overflow:
  - mode=3, const_val=16'h00FF gives lanes {00FF,FF00,00FF,FF00}.
  - mode=2, ramp_step=16'h4000 gives word0 {0000,4000,8000,C000} and word1 wraps to 0000.
- Stop during stall: continuous mode, out_ready=0, stop pulsed → FLUSH holds word. Raising out_ready gives one transfer, then IDLE with done=1. Start and stop together in IDLE → no activity.
- Reset mid-burst: rst_n low during RUN → all outputs 0 asynchronously. Next start restarts the ramp at 0.
- With DAC_PATTERN_GEN_SIG_EN: sig_out matches the model value.
